mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port, read-strobe memory (1-cycle registered read) between the
//  CPU instruction-fetch port and the data-load port. Issues at most one read per cycle,
//  routes each response to its owner and enforces fixed data priority with a starvation bound.
//  Sits between the core's two memory masters and the memory block.
// PARAMETERS
//  STARVE_LIMIT  4   max consecutive data grants while fetch waits; the next grant goes to fetch (>=1)
//  CNT_W         3   width of the starvation counter; must hold STARVE_LIMIT
// PORTS
//  clk          in   1   system clock, all state on posedge
//  reset        in   1   asynchronous, active-high reset
//  if_req       in   1   fetch read request; held with if_addr stable until if_gnt
//  if_addr      in   32  fetch byte address; [1:0] ignored
//  if_gnt       out  1   fetch request accepted this cycle (combinational)
//  if_rvalid    out  1   fetch data valid, exactly 1 cycle after if_gnt
//  if_rdata     out  32  fetch read word
//  d_req        in   1   data read request; held with d_addr stable until d_gnt
//  d_addr       in   32  data byte address; [1:0] ignored
//  d_gnt        out  1   data request accepted this cycle (combinational)
//  d_rvalid     out  1   data valid, exactly 1 cycle after d_gnt
//  d_rdata      out  32  data read word
//  mem_addr     out  32  to memory; address of the granted request, else 0
//  mem_rstrb    out  1   to memory; high in exactly the cycles a grant is given
//  mem_rdata    in   32  from memory; valid the cycle after mem_rstrb, holds otherwise
// BEHAVIOUR
//  Reset (async, immediate): resp_src=IFETCH, resp_pend=0, starve_cnt=0;
//   if_rvalid=d_rvalid=0 while reset is high; gnt/mem_* follow the combinational rules.
//  Grant rule, evaluated combinationally each cycle (reset low):
//   - only d_req: grant data. only if_req: grant fetch. neither: no grant, mem_rstrb=0.
//   - both: grant data unless starve_cnt==STARVE_LIMIT, then grant fetch.
//   - at most one gnt is high per cycle; mem_rstrb = if_gnt | d_gnt.
//  starve_cnt (posedge): data granted while if_req high -> +1 (saturates at STARVE_LIMIT);
//   fetch granted, or if_req low -> 0.
//  Response tracking (posedge): resp_pend <= mem_rstrb; resp_src <= granted source when
//   mem_rstrb, else unchanged.
//  Response outputs (combinational from registers + mem_rdata):
//   if_rvalid = resp_pend & resp_src==IFETCH; d_rvalid = resp_pend & resp_src==DATA.
//   if_rdata = d_rdata = mem_rdata (owner qualifies with its rvalid).
//  Latency: gnt in cycle N -> rvalid+rdata in cycle N+1. Full throughput: back-to-back
//   grants every cycle with no bubbles; a new grant may coincide with the previous rvalid.
//  A requester may keep req high after gnt to issue the next address in the following cycle.
//  Reset asserted mid-transaction: pending response is discarded; no rvalid after release.
//  Address bits [1:0] pass through on mem_addr; the memory ignores them.
// STRUCTURE
//  Shared package (mem_pkg): localparam SRC_IFETCH=1'b0, SRC_DATA=1'b1;
//   MEM_ADDR_W=32, MEM_DATA_W=32.
//  Single module; grant mux, starvation counter and response register are all inline.
//  Optional sub-module mem_arb_starve (counter + limit compare) when reused for a store port.
// TESTING (bench instantiates memory, word 100 = 32'h04030201, word 101 = 32'h08070605)
//  1 d_req=1, d_addr=400 alone -> d_gnt same cycle, next cycle d_rvalid=1, d_rdata=32'h04030201.
//  2 if_req and d_req together (addrs 0, 404) -> data first; d_rdata=32'h08070605; fetch
//    granted the next cycle; no cycle with two rvalids.
//  3 d_req held high 10 cycles, if_req high -> fetch granted on the 5th contended cycle
//    (after 4 data grants); counter then resets and data regains priority.
//  4 fetch streams addrs 0,4,8,12 with req held -> 4 consecutive grants, 4 consecutive
//    if_rvalid beats, rdata in address order.
//  5 reset raised the cycle after a d_gnt -> d_rvalid stays 0; after release, idle until new req.
//  6 no requests for 20 cycles -> mem_rstrb=0, mem_addr=0, both rvalid=0 throughout.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: response-source encoding and bus widths.
package mem_pkg;

  localparam logic SRC_IFETCH = 1'b0;
  localparam logic SRC_DATA   = 1'b1;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one read-strobe memory (1-cycle registered read) between instruction fetch and data load.
// Data wins contention until fetch has waited through STARVE_LIMIT data grants.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [MEM_ADDR_W-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [MEM_DATA_W-1:0] if_rdata,
  input  logic                  d_req,
  input  logic [MEM_ADDR_W-1:0] d_addr,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [MEM_DATA_W-1:0] d_rdata,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_rstrb,
  input  logic [MEM_DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             resp_pend_q;
  logic             resp_src_q, resp_src_d;
  logic             starved;

  // Grant mux: at most one grant, and the strobe is exactly the OR of the grants.
  always_comb begin
    starved   = (starve_q == Limit);
    d_gnt     = d_req & ~(if_req & starved);
    if_gnt    = if_req & ~d_gnt;
    mem_rstrb = if_gnt | d_gnt;
    mem_addr  = '0;
    if (d_gnt) begin
      mem_addr = d_addr;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  // Count only data grants that made a waiting fetch wait longer.
  always_comb begin
    starve_d = '0;
    if (d_gnt && if_req) begin
      starve_d = starved ? starve_q : starve_q + CNT_W'(1);
    end
    resp_src_d = resp_src_q;
    if (mem_rstrb) begin
      resp_src_d = d_gnt ? SRC_DATA : SRC_IFETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q    <= '0;
      resp_pend_q <= 1'b0;
      resp_src_q  <= SRC_IFETCH;
    end else begin
      starve_q    <= starve_d;
      resp_pend_q <= mem_rstrb;
      resp_src_q  <= resp_src_d;
    end
  end

  assign if_rvalid = resp_pend_q & (resp_src_q == SRC_IFETCH);
  assign d_rvalid  = resp_pend_q & (resp_src_q == SRC_DATA);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle registered-read memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req;
  logic [31:0] if_addr, d_addr;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_rstrb;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_rdata;
  logic [31:0] mem [0:127];

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] W0   = 32'hA500_0000;
  localparam logic [31:0] W1   = 32'hA500_0001;
  localparam logic [31:0] W2   = 32'hA500_0002;
  localparam logic [31:0] W3   = 32'hA500_0003;
  localparam logic [31:0] W100 = 32'h0403_0201;
  localparam logic [31:0] W101 = 32'h0807_0605;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        e_if_rvalid;
    logic        e_d_rvalid;
    logic [31:0] e_rdata;
    logic [31:0] e_mem_addr;
  } vec_t;

  vec_t vecs[$];

  mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_addr    (d_addr),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[100] = W100;
    mem[101] = W101;
  end

  always_ff @(posedge clk) begin
    if (mem_rstrb) mem_rdata <= mem[mem_addr[8:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic [31:0] da, input logic eig, input logic edg,
                              input logic eiv, input logic edv, input logic [31:0] erd,
                              input logic [31:0] ema);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_addr = da;
    v.e_if_gnt = eig; v.e_d_gnt = edg; v.e_if_rvalid = eiv; v.e_d_rvalid = edv;
    v.e_rdata = erd; v.e_mem_addr = ema;
    return v;
  endfunction

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da);
    if_req = ir; if_addr = ia; d_req = dr; d_addr = da;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
    chk({tag, "_d_rvalid"},  32'(d_rvalid),  32'd0);
    chk({tag, "_mem_rstrb"}, 32'(mem_rstrb), 32'd0);
    chk({tag, "_mem_addr"},  mem_addr,       32'd0);
  endtask

  initial begin
    // Single data read, then address low bits passing through unchanged.
    vecs.push_back(mk(0, 0, 1, 400, 0, 1, 0, 0, 0, 400));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 1, W100, 0));
    vecs.push_back(mk(0, 0, 1, 403, 0, 1, 0, 0, 0, 403));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 1, W100, 0));
    // Simultaneous requests: data first, fetch next cycle.
    vecs.push_back(mk(1, 0, 1, 404, 0, 1, 0, 0, 0, 404));
    vecs.push_back(mk(1, 0, 0, 0,   1, 0, 0, 1, W101, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 1, 0, W0, 0));
    // Sustained contention: fetch forced through after 4 data grants, twice.
    vecs.push_back(mk(1, 8, 1, 404, 0, 1, 0, 0, 0, 404));
    vecs.push_back(mk(1, 8, 1, 404, 0, 1, 0, 1, W101, 404));
    vecs.push_back(mk(1, 8, 1, 404, 0, 1, 0, 1, W101, 404));
    vecs.push_back(mk(1, 8, 1, 404, 0, 1, 0, 1, W101, 404));
    vecs.push_back(mk(1, 8, 1, 404, 1, 0, 0, 1, W101, 8));
    vecs.push_back(mk(1, 8, 1, 404, 0, 1, 1, 0, W2, 404));
    vecs.push_back(mk(1, 8, 1, 404, 0, 1, 0, 1, W101, 404));
    vecs.push_back(mk(1, 8, 1, 404, 0, 1, 0, 1, W101, 404));
    vecs.push_back(mk(1, 8, 1, 404, 0, 1, 0, 1, W101, 404));
    vecs.push_back(mk(1, 8, 1, 404, 1, 0, 0, 1, W101, 8));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 1, 0, W2, 0));
    // Fetch stream, back-to-back grants and beats.
    vecs.push_back(mk(1, 0,  0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4,  0, 0, 1, 0, 1, 0, W0, 4));
    vecs.push_back(mk(1, 8,  0, 0, 1, 0, 1, 0, W1, 8));
    vecs.push_back(mk(1, 12, 0, 0, 1, 0, 1, 0, W2, 12));
    vecs.push_back(mk(0, 0,  0, 0, 0, 0, 1, 0, W3, 0));

    reset = 1'b1;
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_d_gnt",  32'(d_gnt),  32'd0);
    chk_quiet("rst");
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1 drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].d_req, vecs[i].d_addr);
      @(negedge clk);
      chk($sformatf("v%0d_if_gnt", i),    32'(if_gnt),    32'(vecs[i].e_if_gnt));
      chk($sformatf("v%0d_d_gnt", i),     32'(d_gnt),     32'(vecs[i].e_d_gnt));
      chk($sformatf("v%0d_mem_rstrb", i), 32'(mem_rstrb),
          32'(vecs[i].e_if_gnt | vecs[i].e_d_gnt));
      chk($sformatf("v%0d_mem_addr", i),  mem_addr,       vecs[i].e_mem_addr);
      chk($sformatf("v%0d_if_rvalid", i), 32'(if_rvalid), 32'(vecs[i].e_if_rvalid));
      chk($sformatf("v%0d_d_rvalid", i),  32'(d_rvalid),  32'(vecs[i].e_d_rvalid));
      if (vecs[i].e_if_rvalid) chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_rdata);
      if (vecs[i].e_d_rvalid)  chk($sformatf("v%0d_d_rdata", i),  d_rdata,  vecs[i].e_rdata);
    end

    // Reset raised the cycle after a data grant discards the pending response at once.
    @(posedge clk);
    #1 drive(0, 0, 1, 400);
    @(negedge clk);
    chk("mid_rst_d_gnt", 32'(d_gnt), 32'd1);
    @(posedge clk);
    #1 drive(0, 0, 0, 0);
    reset = 1'b1;
    #1 chk("mid_rst_async_d_rvalid", 32'(d_rvalid), 32'd0);
    @(negedge clk);
    chk_quiet("mid_rst_hold");
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_quiet($sformatf("post_rst%0d", i));
    end

    // Long idle stretch.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_quiet($sformatf("idle%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
